audio_fir_sequencer: RTL and testbench

AUDIO_FIR_SEQUENCER -- requirements
Module: audio_fir_sequencer

---
 rtl/audio_fir_sequencer_if.sv | 35 +++
 rtl/audio_fir_sequencer.sv | 144 ++++++++++++++
 tb/tb_audio_fir_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_fir_sequencer_if.sv
// Bus bundle between the FIR sequencer and its ADC FIFO, filter pair and DAC FIFO.
// master = sequencer side, slave = surrounding environment.
`timescale 1ns/1ps
interface audio_fir_sequencer_if #(parameter int DATA_WIDTH = 32);
    logic                  adcfifo_empty;
    logic                  adcfifo_read;
    logic [DATA_WIDTH-1:0] adcfifo_readdata;
    logic                  fir_rfi_i;
    logic                  fir_valid_o;
    logic                  fir_sync_o;
    logic [15:0]           fir_data_a_o;
    logic [15:0]           fir_data_b_o;
    logic                  fir_valid_i;
    logic [15:0]           fir_data_a_i;
    logic [15:0]           fir_data_b_i;
    logic                  dacfifo_full;
    logic                  dacfifo_write;
    logic [DATA_WIDTH-1:0] dacfifo_writedata;
    logic                  overflow_o;
    logic                  busy_o;

    modport master (
        input  adcfifo_empty, adcfifo_readdata, fir_rfi_i, fir_valid_i,
               fir_data_a_i, fir_data_b_i, dacfifo_full,
        output adcfifo_read, fir_valid_o, fir_sync_o, fir_data_a_o, fir_data_b_o,
               dacfifo_write, dacfifo_writedata, overflow_o, busy_o
    );

    modport slave (
        output adcfifo_empty, adcfifo_readdata, fir_rfi_i, fir_valid_i,
               fir_data_a_i, fir_data_b_i, dacfifo_full,
        input  adcfifo_read, fir_valid_o, fir_sync_o, fir_data_a_o, fir_data_b_o,
               dacfifo_write, dacfifo_writedata, overflow_o, busy_o
    );
endinterface

// File: rtl/audio_fir_sequencer.sv
// Streams stereo ADC words through a FIR pair into a small result FIFO drained to the DAC.
// Optional macro AUDIO_SAT_GAIN_EN adds gain_i: saturating left shift on drained samples.
`timescale 1ns/1ps
module audio_fir_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_DEPTH  = 4
) (
    input  logic clk,
    input  logic reset_n,
`ifdef AUDIO_SAT_GAIN_EN
    input  logic [2:0] gain_i,
`endif
    audio_fir_sequencer_if.master bus
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
    localparam logic [CW:0]   DEPTH_S = (CW + 1)'(OUT_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(OUT_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, POP, LATCH, ISSUE} state_t;

    state_t        state_q;
    logic          adc_read_q, fir_valid_q, fir_sync_q;
    logic [15:0]   fir_a_q, fir_b_q;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   mem_q [OUT_DEPTH];

    logic          drain, capture, issue, start;
    logic [31:0]   head, out_word;

`ifdef AUDIO_SAT_GAIN_EN
    function automatic logic [15:0] sat_shift(input logic [15:0] s, input logic [2:0] g);
        logic signed [23:0] w;
        w = {{8{s[15]}}, s};
        w = w <<< g;
        if (w > 24'sd32767)       return 16'h7FFF;
        else if (w < -24'sd32768) return 16'h8000;
        else                      return w[15:0];
    endfunction
`endif

    always_comb begin
        drain   = (occ_q != '0) && !bus.dacfifo_full;
        // A full buffer still accepts a result when a word leaves in the same cycle.
        capture = bus.fir_valid_i && ((occ_q != DEPTH_C) || drain);
        issue   = (state_q == ISSUE);
        start   = !bus.adcfifo_empty && bus.fir_rfi_i &&
                  (({1'b0, inflight_q} + {1'b0, occ_q}) < DEPTH_S);

        inflight_d = inflight_q;
        if (issue && !bus.fir_valid_i)
            inflight_d = inflight_q + 1'b1;
        else if (!issue && bus.fir_valid_i && (inflight_q != '0))
            inflight_d = inflight_q - 1'b1;

        occ_d = occ_q;
        if (capture && !drain)      occ_d = occ_q + 1'b1;
        else if (drain && !capture) occ_d = occ_q - 1'b1;

        wr_ptr_d = wr_ptr_q;
        if (capture) wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q;
        if (drain)   rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + 1'b1;

        overflow_d = overflow_q | (bus.fir_valid_i & ~capture);

        head = mem_q[rd_ptr_q];
`ifdef AUDIO_SAT_GAIN_EN
        out_word = {sat_shift(head[31:16], gain_i), sat_shift(head[15:0], gain_i)};
`else
        out_word = head;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            adc_read_q  <= 1'b0;
            fir_valid_q <= 1'b0;
            fir_sync_q  <= 1'b0;
            fir_a_q     <= '0;
            fir_b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q    <= POP;
                    adc_read_q <= 1'b1;
                end
                POP: begin
                    adc_read_q <= 1'b0;
                    state_q    <= LATCH;
                end
                LATCH: begin
                    fir_a_q     <= bus.adcfifo_readdata[15:0];
                    fir_b_q     <= bus.adcfifo_readdata[31:16];
                    fir_valid_q <= 1'b1;
                    fir_sync_q  <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    fir_valid_q <= 1'b0;
                    fir_sync_q  <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (capture) mem_q[wr_ptr_q] <= {bus.fir_data_b_i, bus.fir_data_a_i};
    end

    assign bus.adcfifo_read      = adc_read_q;
    assign bus.fir_valid_o       = fir_valid_q;
    assign bus.fir_sync_o        = fir_sync_q;
    assign bus.fir_data_a_o      = fir_a_q;
    assign bus.fir_data_b_o      = fir_b_q;
    assign bus.dacfifo_write     = drain;
    assign bus.dacfifo_writedata = drain ? DATA_WIDTH'(out_word) : '0;
    assign bus.overflow_o        = overflow_q;
    assign bus.busy_o            = (state_q != IDLE) | (inflight_q != '0) | (occ_q != '0);
endmodule

// File: tb/tb_audio_fir_sequencer.sv
// Directed bench for audio_fir_sequencer: ADC FIFO, filter-pair and DAC FIFO models.
`timescale 1ns/1ps
module tb_audio_fir_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    audio_fir_sequencer_if #(.DATA_WIDTH(32)) bus();

    logic        empty = 1'b1, rfi = 1'b1, full = 1'b0, man_valid = 1'b0;
    logic [15:0] man_a = '0, man_b = '0;
    logic        seq_en = 1'b0, auto_en = 1'b0;
    logic [31:0] fixed_word = '0, seq_word = '0;
    int          seq_k = 0;
    logic        auto_valid = 1'b0, pend = 1'b0;
    logic [15:0] auto_a = '0, auto_b = '0, pend_a = '0, pend_b = '0;
    int          pop_cnt = 0, push_cnt = 0;
    int          checks = 0, errors = 0;
`ifdef AUDIO_SAT_GAIN_EN
    logic [2:0]  gain = 3'd0;
`endif

    assign bus.adcfifo_empty    = empty;
    assign bus.adcfifo_readdata = seq_en ? seq_word : fixed_word;
    assign bus.fir_rfi_i        = rfi;
    assign bus.fir_valid_i      = man_valid | auto_valid;
    assign bus.fir_data_a_i     = man_valid ? man_a : auto_a;
    assign bus.fir_data_b_i     = man_valid ? man_b : auto_b;
    assign bus.dacfifo_full     = full;

    audio_fir_sequencer #(.DATA_WIDTH(32), .OUT_DEPTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef AUDIO_SAT_GAIN_EN
        .gain_i(gain),
`endif
        .bus(bus)
    );

    // Filter model: result = {b, a+1}, returned the cycle after the issue.
    always @(negedge clk) begin
        auto_valid = pend;
        auto_a     = pend_a;
        auto_b     = pend_b;
        pend       = auto_en && bus.fir_valid_o;
        pend_a     = bus.fir_data_a_o + 16'h0001;
        pend_b     = bus.fir_data_b_o;
    end

    // ADC FIFO model: k-th popped word is {0x5000+k, 0x0100+k}, valid the cycle after the pop.
    always @(negedge clk) begin
        if (bus.adcfifo_read) begin
            seq_word = {16'h5000 + 16'(seq_k), 16'h0100 + 16'(seq_k)};
            seq_k++;
        end
    end

    always @(posedge clk) begin
        if (bus.adcfifo_read)  pop_cnt++;
        if (bus.dacfifo_write) push_cnt++;
    end

    function automatic logic [31:0] exp_word(input int k);
        return {16'h5000 + 16'(k), 16'h0101 + 16'(k)};
    endfunction

    task automatic refill(output int base);
        base = seq_k;
        full = 1'b1; seq_en = 1'b1; auto_en = 1'b1; empty = 1'b0;
        repeat (60) @(negedge clk);
        empty = 1'b1; auto_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.adcfifo_read, bus.fir_valid_o, bus.fir_sync_o, bus.dacfifo_write,
             bus.overflow_o, bus.busy_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000", {bus.adcfifo_read, bus.fir_valid_o,
                     bus.fir_sync_o, bus.dacfifo_write, bus.overflow_o, bus.busy_o});
        end
        checks++;
        if ({bus.fir_data_b_o, bus.fir_data_a_o} !== 32'h0 || bus.dacfifo_writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0/0", {bus.fir_data_b_o, bus.fir_data_a_o},
                     bus.dacfifo_writedata);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_issue;
        logic seen;
        seen = 1'b0;
        fixed_word = 32'h1234ABCD; empty = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.adcfifo_read) begin seen = 1'b1; break; end
        end
        empty = 1'b1;
        checks++;
        if (!seen) begin errors++; $display("FAIL pop_timeout got none want adcfifo_read"); end
        @(negedge clk);
        checks++;
        if ({bus.adcfifo_read, bus.fir_valid_o} !== 2'b00) begin
            errors++; $display("FAIL pop_pulse got %b want 00", {bus.adcfifo_read, bus.fir_valid_o});
        end
        @(negedge clk);
        checks++;
        if ({bus.fir_valid_o, bus.fir_sync_o} !== 2'b11) begin
            errors++; $display("FAIL issue_strobe got %b want 11", {bus.fir_valid_o, bus.fir_sync_o});
        end
        checks++;
        if ({bus.fir_data_b_o, bus.fir_data_a_o} !== 32'h1234ABCD) begin
            errors++; $display("FAIL issue_data got %h want 1234abcd", {bus.fir_data_b_o, bus.fir_data_a_o});
        end
        @(negedge clk);
        checks++;
        if (bus.fir_valid_o !== 1'b0 || {bus.fir_data_b_o, bus.fir_data_a_o} !== 32'h1234ABCD ||
            bus.busy_o !== 1'b1) begin
            errors++; $display("FAIL issue_hold got v=%b d=%h busy=%b want 0/1234abcd/1",
                               bus.fir_valid_o, {bus.fir_data_b_o, bus.fir_data_a_o}, bus.busy_o);
        end
        man_valid = 1'b1; man_a = 16'h0001; man_b = 16'h0002;
        @(negedge clk);
        man_valid = 1'b0;
        checks++;
        if (bus.dacfifo_write !== 1'b1 || bus.dacfifo_writedata !== 32'h00020001) begin
            errors++; $display("FAIL drain_first got w=%b d=%h want 1/00020001",
                               bus.dacfifo_write, bus.dacfifo_writedata);
        end
        @(negedge clk);
        checks++;
        if ({bus.dacfifo_write, bus.busy_o} !== 2'b00) begin
            errors++; $display("FAIL drain_idle got %b want 00", {bus.dacfifo_write, bus.busy_o});
        end
    endtask

    task automatic test_full_stall;
        int base, p0;
        base = seq_k; p0 = pop_cnt;
        full = 1'b1; seq_en = 1'b1; auto_en = 1'b1; empty = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (pop_cnt - p0 != 4) begin errors++; $display("FAIL stall_pops got %0d want 4", pop_cnt - p0); end
        checks++;
        if ({bus.overflow_o, bus.busy_o} !== 2'b01) begin
            errors++; $display("FAIL stall_flags got %b want 01", {bus.overflow_o, bus.busy_o});
        end
        empty = 1'b1; auto_en = 1'b0;
        @(negedge clk);
        full = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.dacfifo_write !== 1'b1 || bus.dacfifo_writedata !== exp_word(base + i)) begin
                errors++; $display("FAIL stall_push%0d got w=%b d=%h want 1/%h", i,
                                   bus.dacfifo_write, bus.dacfifo_writedata, exp_word(base + i));
            end
            @(negedge clk); #1;
        end
        checks++;
        if (bus.dacfifo_write !== 1'b0) begin errors++; $display("FAIL stall_end got 1 want 0"); end
    endtask

    task automatic test_full_simul;
        int base;
        refill(base);
        full = 1'b0; man_valid = 1'b1; man_a = 16'h7777; man_b = 16'h6666; #1;
        checks++;
        if (bus.dacfifo_write !== 1'b1 || bus.dacfifo_writedata !== exp_word(base)) begin
            errors++; $display("FAIL simul_push0 got w=%b d=%h want 1/%h",
                               bus.dacfifo_write, bus.dacfifo_writedata, exp_word(base));
        end
        @(negedge clk);
        man_valid = 1'b0; #1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (bus.dacfifo_writedata !== exp_word(base + i)) begin
                errors++; $display("FAIL simul_push%0d got %h want %h", i,
                                   bus.dacfifo_writedata, exp_word(base + i));
            end
            @(negedge clk); #1;
        end
        checks++;
        if (bus.dacfifo_write !== 1'b1 || bus.dacfifo_writedata !== 32'h66667777) begin
            errors++; $display("FAIL simul_last got w=%b d=%h want 1/66667777",
                               bus.dacfifo_write, bus.dacfifo_writedata);
        end
        @(negedge clk);
        checks++;
        if ({bus.dacfifo_write, bus.overflow_o, bus.busy_o} !== 3'b000) begin
            errors++; $display("FAIL simul_end got %b want 000",
                               {bus.dacfifo_write, bus.overflow_o, bus.busy_o});
        end
    endtask

    task automatic test_overflow;
        int base, p;
        refill(base);
        man_valid = 1'b1; man_a = 16'hDEAD; man_b = 16'hBEEF;
        @(negedge clk);
        man_valid = 1'b0;
        checks++;
        if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got 0 want 1"); end
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.overflow_o, bus.busy_o} !== 2'b11) begin
            errors++; $display("FAIL ovf_sticky got %b want 11", {bus.overflow_o, bus.busy_o});
        end
        p = push_cnt;
        full = 1'b0; #1;
        checks++;
        if (bus.dacfifo_writedata !== exp_word(base)) begin
            errors++; $display("FAIL ovf_head got %h want %h", bus.dacfifo_writedata, exp_word(base));
        end
        repeat (10) @(negedge clk);
        checks++;
        if (push_cnt - p != 4 || bus.overflow_o !== 1'b1) begin
            errors++; $display("FAIL ovf_drain got pushes=%0d ovf=%b want 4/1", push_cnt - p, bus.overflow_o);
        end
    endtask

    task automatic test_reset_mid;
        int k, p;
        k = 0;
        full = 1'b1; seq_en = 1'b1; auto_en = 1'b1; empty = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.adcfifo_read) begin k++; if (k == 3) break; end
        end
        checks++;
        if (k != 3) begin errors++; $display("FAIL mid_timeout got %0d pops want 3", k); end
        @(negedge clk);
        reset_n = 1'b0; #1;
        checks++;
        if ({bus.adcfifo_read, bus.fir_valid_o, bus.fir_sync_o, bus.dacfifo_write,
             bus.overflow_o, bus.busy_o} !== 6'b0) begin
            errors++; $display("FAIL mid_ctrl got %b want 000000", {bus.adcfifo_read, bus.fir_valid_o,
                               bus.fir_sync_o, bus.dacfifo_write, bus.overflow_o, bus.busy_o});
        end
        checks++;
        if ({bus.fir_data_b_o, bus.fir_data_a_o} !== 32'h0 || bus.dacfifo_writedata !== 32'h0) begin
            errors++; $display("FAIL mid_data got %h/%h want 0/0",
                               {bus.fir_data_b_o, bus.fir_data_a_o}, bus.dacfifo_writedata);
        end
        auto_en = 1'b0; empty = 1'b1; full = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        p = push_cnt;
        repeat (10) @(negedge clk);
        checks++;
        if (push_cnt != p || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL mid_after got pushes=%0d busy=%b want 0/0", push_cnt - p, bus.busy_o);
        end
    endtask

`ifdef AUDIO_SAT_GAIN_EN
    task automatic test_gain;
        logic [15:0] ain [3];
        logic [15:0] aout [3];
        ain  = '{16'h0100, 16'h2000, 16'hC000};
        aout = '{16'h0800, 16'h7FFF, 16'h8000};
        gain = 3'd3; full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            man_valid = 1'b1; man_a = ain[i]; man_b = 16'h0001;
            @(negedge clk);
        end
        man_valid = 1'b0; full = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.dacfifo_writedata !== {16'h0008, aout[i]}) begin
                errors++; $display("FAIL gain%0d got %h want %h", i, bus.dacfifo_writedata, {16'h0008, aout[i]});
            end
            @(negedge clk); #1;
        end
    endtask
`else
    task automatic test_passthrough;
        logic [31:0] w [2];
        w = '{32'h8001C000, 32'h7FFF2000};
        full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            man_valid = 1'b1; man_a = w[i][15:0]; man_b = w[i][31:16];
            @(negedge clk);
        end
        man_valid = 1'b0; full = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.dacfifo_writedata !== w[i]) begin
                errors++; $display("FAIL pass%0d got %h want %h", i, bus.dacfifo_writedata, w[i]);
            end
            @(negedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_issue;
        test_full_stall;
        test_full_simul;
        test_overflow;
        test_reset_mid;
`ifdef AUDIO_SAT_GAIN_EN
        test_gain;
`else
        test_passthrough;
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200us");
        $fatal(1, "watchdog");
    end
endmodule
